// File: rtl/bin2bcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_ctrl
// Purpose  : Two-port round-robin arbiter and sequencer for the double-dabble
//            BCD datapath. Grants one 16-bit request at a time, strobes the
//            datapath through load / add / shift, and returns a registered
//            4-digit packed BCD result with done, ack and overflow.
// Revision : 1.0  initial release
// ============================================================================
module bin2bcd_ctrl #(
    parameter logic [15:0] OVF_LIMIT = 16'd9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] bin0,
    input  logic [15:0] bin1,
    output logic        ack0,
    output logic        ack1,
    output logic        load_en,
    output logic        add_en,
    output logic        shift_en,
    output logic [15:0] binary_in,
    input  logic [31:0] shift_reg,
    input  logic [4:0]  bit_count,
    output logic [15:0] bcd_out,
    output logic        done,
    output logic        done_id,
    output logic        overflow,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ADD    = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;

    logic        r_last;
    logic        r_grant;
    logic        r_ovf_pend;
    logic [15:0] r_binary_in;

    logic [15:0] r_bcd_out;
    logic        r_done;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_done_id;
    logic        r_overflow;

    logic        w_start;
    logic        w_winner;
    logic [15:0] w_operand;
    logic        w_finish;

    // The low half of the datapath register is the binary shift-out area;
    // only the BCD digits in the upper half matter here.
    logic        w_unused_low;
    assign w_unused_low = ^shift_reg[15:0];

    // A new grant is blocked in the ack cycle so a held request is treated
    // as a fresh one only from the following cycle.
    assign w_start   = (r_state == S_IDLE) && !r_ack0 && !r_ack1 && (req0 || req1);
    // Sole requester wins; on a tie the port that was not served last wins.
    assign w_winner  = (req0 && req1) ? ~r_last : req1;
    assign w_operand = w_winner ? bin1 : bin0;
    assign w_finish  = (r_state == S_FINISH);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; bit_count==1 during SHIFT means the final shift
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = w_start ? S_LOAD : S_IDLE;
            S_LOAD:   w_state_next = S_ADD;
            S_ADD:    w_state_next = (bit_count == 5'd0) ? S_FINISH : S_SHIFT;
            S_SHIFT:  w_state_next = (bit_count == 5'd1) ? S_FINISH : S_ADD;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Datapath strobes and busy, decoded from the current state
    always_comb begin
        load_en  = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_LOAD:  load_en  = 1'b1;
            S_ADD:   add_en   = 1'b1;
            S_SHIFT: shift_en = 1'b1;
            default: ;
        endcase
    end

    // Grant bookkeeping: latch winner, operand and overflow flag at grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last      <= 1'b1;
            r_grant     <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_binary_in <= 16'd0;
        end else if (w_start) begin
            r_last      <= w_winner;
            r_grant     <= w_winner;
            r_ovf_pend  <= (w_operand > OVF_LIMIT);
            r_binary_in <= w_operand;
        end
    end

    // Result capture on FINISH exit; done/ack are single-cycle pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bcd_out  <= 16'd0;
            r_done     <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_done_id  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_ack0 <= w_finish && !r_grant;
            r_ack1 <= w_finish && r_grant;
            if (w_finish) begin
                r_bcd_out  <= shift_reg[31:16];
                r_done_id  <= r_grant;
                r_overflow <= r_ovf_pend;
            end
        end
    end

    assign binary_in = r_binary_in;
    assign bcd_out   = r_bcd_out;
    assign done      = r_done;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign done_id   = r_done_id;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_ctrl
// Purpose  : Self-checking bench for bin2bcd_ctrl with a behavioural
//            double-dabble datapath and a cycle-count reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bin2bcd_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] bin0 = 16'd0;
    logic [15:0] bin1 = 16'd0;
    logic        ack0, ack1, load_en, add_en, shift_en;
    logic [15:0] binary_in, bcd_out;
    logic        done, done_id, overflow, busy;
    logic [31:0] dp_sr = 32'd0;
    logic [4:0]  dp_cnt = 5'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin2bcd_ctrl #(.OVF_LIMIT(16'd9999)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .bin0      (bin0),
        .bin1      (bin1),
        .ack0      (ack0),
        .ack1      (ack1),
        .load_en   (load_en),
        .add_en    (add_en),
        .shift_en  (shift_en),
        .binary_in (binary_in),
        .shift_reg (dp_sr),
        .bit_count (dp_cnt),
        .bcd_out   (bcd_out),
        .done      (done),
        .done_id   (done_id),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packed BCD of value mod 10000, from decimal arithmetic
    function automatic logic [15:0] to_bcd(input logic [15:0] val);
        int v;
        v = int'(val) % 10000;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] dd_add(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 4; i++)
            if (r[16 + 4*i +: 4] >= 4'd5) r[16 + 4*i +: 4] = r[16 + 4*i +: 4] + 4'd3;
        return r;
    endfunction

    // Behavioural datapath (not reset by the controller)
    always @(posedge clk) begin
        if (load_en) begin
            dp_sr  <= {16'd0, binary_in};
            dp_cnt <= 5'd16;
        end else if (add_en) begin
            dp_sr  <= dd_add(dp_sr);
        end else if (shift_en) begin
            dp_sr  <= dp_sr << 1;
            dp_cnt <= dp_cnt - 5'd1;
        end
    end

    // Reference model: conversion tracked as a cycle count 0 (idle) .. 34
    int          m_cnt = 0;
    logic        m_last = 1'b1;
    logic        m_grant = 1'b0;
    logic [15:0] m_op = 16'd0;
    logic        m_done = 1'b0, m_ack0 = 1'b0, m_ack1 = 1'b0, m_id = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_bcd = 16'd0;
    int          c_load = 0, c_add = 0, c_shift = 0;

    always @(negedge clk) begin
        logic e_load, e_add, e_shift, was_ack;
        if (!reset) begin
            m_cnt = 0; m_last = 1'b1; m_grant = 1'b0; m_op = 16'd0;
            m_done = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0; m_id = 1'b0; m_ovf = 1'b0;
            m_bcd = 16'd0;
        end
        e_load  = (m_cnt == 1);
        e_add   = (m_cnt >= 2) && (m_cnt <= 33) && (m_cnt % 2 == 0);
        e_shift = (m_cnt >= 3) && (m_cnt <= 33) && (m_cnt % 2 == 1);
        chk("load_en",   load_en,   e_load);
        chk("add_en",    add_en,    e_add);
        chk("shift_en",  shift_en,  e_shift);
        chk("busy",      busy,      m_cnt != 0);
        chk("done",      done,      m_done);
        chk("ack0",      ack0,      m_ack0);
        chk("ack1",      ack1,      m_ack1);
        chk("bcd_out",   bcd_out,   m_bcd);
        chk("done_id",   done_id,   m_id);
        chk("overflow",  overflow,  m_ovf);
        chk("binary_in", binary_in, m_op);

        if (!reset) begin
            c_load = 0; c_add = 0; c_shift = 0;
        end else begin
            c_load  += int'(load_en);
            c_add   += int'(add_en);
            c_shift += int'(shift_en);
            if (done) begin
                chk("load_count",  c_load,  1);
                chk("add_count",   c_add,   16);
                chk("shift_count", c_shift, 16);
                c_load = 0; c_add = 0; c_shift = 0;
            end
        end

        if (reset) begin
            was_ack = m_ack0 || m_ack1;
            m_done = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
            if (m_cnt == 34) begin
                m_cnt  = 0;
                m_done = 1'b1;
                m_ack0 = !m_grant;
                m_ack1 = m_grant;
                m_id   = m_grant;
                m_ovf  = (m_op > 16'd9999);
                m_bcd  = to_bcd(m_op);
            end else if (m_cnt > 0) begin
                m_cnt++;
            end else if (!was_ack && (req0 || req1)) begin
                if (req0 && req1) m_grant = !m_last;
                else              m_grant = req1;
                m_last = m_grant;
                m_op   = m_grant ? bin1 : bin0;
                m_cnt  = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit port, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((port ? ack1 : ack0) == 1'b0) && n < 200);
        chk(port ? "ack1_seen" : "ack0_seen", port ? ack1 : ack0, 1'b1);
    endtask

    // One directed conversion started from an idle, non-ack cycle
    task automatic conv(input bit port, input logic [15:0] val,
                        input logic [15:0] exp_bcd, input logic exp_ovf);
        int n;
        if (port) begin bin1 = val; req1 = 1'b1; end
        else      begin bin0 = val; req0 = 1'b1; end
        wait_ack(port, n);
        chk("latency",   n,        35);
        chk("lit_bcd",   bcd_out,  exp_bcd);
        chk("lit_ovf",   overflow, exp_ovf);
        chk("lit_id",    done_id,  port);
        chk("lit_done",  done,     1'b1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("busy_after", busy, 1'b0);
    endtask

    function automatic logic [15:0] rnd_val();
        case ($urandom % 4)
            0:       return 16'($urandom % 10000);
            1:       return 16'($urandom_range(10005, 9995));
            2:       return 16'($urandom);
            default: return 16'($urandom % 21);
        endcase
    endfunction

    initial begin
        int n, t0, t1;
        bit got0, got1, first_set, first;

        repeat (3) tick();
        chk("rst_bcd",   bcd_out,   16'h0000);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_bin",   binary_in, 16'h0000);
        reset = 1'b1;
        tick();

        conv(0, 16'd1234,  16'h1234, 1'b0);
        conv(0, 16'd0,     16'h0000, 1'b0);
        conv(0, 16'd9999,  16'h9999, 1'b0);
        conv(1, 16'd65535, 16'h5535, 1'b1);
        conv(1, 16'd10000, 16'h0000, 1'b1);

        // Simultaneous requests right after reset: port 0 wins the tie
        reset = 1'b0; tick(); reset = 1'b1; tick();
        bin0 = 16'd7; bin1 = 16'd42; req0 = 1'b1; req1 = 1'b1;
        got0 = 0; got1 = 0; first_set = 0; first = 0; t0 = 0; t1 = 0;
        for (int c = 1; c < 200 && !(got0 && got1); c++) begin
            tick();
            if (ack0) begin
                chk("tie_bcd0", bcd_out, 16'h0007);
                chk("tie_id0",  done_id, 1'b0);
                if (!first_set) begin first = 0; first_set = 1; end
                got0 = 1; t0 = c; req0 = 1'b0;
            end
            if (ack1) begin
                chk("tie_bcd1", bcd_out, 16'h0042);
                chk("tie_id1",  done_id, 1'b1);
                if (!first_set) begin first = 1; first_set = 1; end
                got1 = 1; t1 = c; req1 = 1'b0;
            end
        end
        chk("tie_first",  first, 1'b0);
        chk("tie_t0",     t0,    35);
        chk("tie_t1",     t1,    71);
        tick();

        // Reset in cycle 20 of a conversion aborts it
        bin0 = 16'd3333; req0 = 1'b1;
        repeat (20) tick();
        reset = 1'b0;
        #1;
        chk("abort_busy",  busy,      1'b0);
        chk("abort_done",  done,      1'b0);
        chk("abort_bcd",   bcd_out,   16'h0000);
        chk("abort_bin",   binary_in, 16'h0000);
        chk("abort_shift", shift_en | add_en | load_en, 1'b0);
        tick(); tick();
        req0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        conv(0, 16'd250, 16'h0250, 1'b0);

        // Request held through ack is re-granted in cycle 36
        bin0 = 16'd1111; req0 = 1'b1;
        wait_ack(0, n);
        chk("held_lat1", n, 35);
        chk("held_bcd1", bcd_out, 16'h1111);
        bin0 = 16'd2222;
        wait_ack(0, n);
        chk("held_lat2", n, 36);
        chk("held_bcd2", bcd_out, 16'h2222);
        req0 = 1'b0;
        tick();

        // Randomized traffic on both ports
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (ack0) begin
                if ($urandom % 2) bin0 = rnd_val();
                else              req0 = 1'b0;
            end else if (!req0 && ($urandom % 4 == 0)) begin
                bin0 = rnd_val(); req0 = 1'b1;
            end
            if (ack1) begin
                if ($urandom % 2) bin1 = rnd_val();
                else              req1 = 1'b0;
            end else if (!req1 && ($urandom % 4 == 0)) begin
                bin1 = rnd_val(); req1 = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (80) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin2bcd_ctrl.md
# bin2bcd_ctrl

Controller and two-port arbiter for the `bin2bcd_datapath` double-dabble converter in the calculator FPGA. It accepts 16-bit binary conversion requests from two requesters, such as the result path and the operand display path. It grants the converter round-robin, drives the datapath's `load_en`, `add_en` and `shift_en` strobes, and returns a 4-digit packed BCD result with done/ack and overflow.

## Interface
- `OVF_LIMIT`, default 9999: largest operand representable in 4 BCD digits; larger values flag overflow.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `req0`, `req1`  in  1  conversion request; held high until the matching ack.
- `bin0`, `bin1`  in  16  operands; must be stable from req rise until the grant edge.
- `ack0`, `ack1`  out  1  one-cycle pulse, coincident with `done` for the granted port.
- `load_en`, `add_en`, `shift_en`  out  1  datapath strobes; at most one high per cycle.
- `binary_in`  out  16  latched operand to the datapath.
- `shift_reg`  in  32  datapath register; [31:16] holds the BCD digits.
- `bit_count`  in  5  datapath remaining-bit counter.
- `bcd_out`  out  16  {thousands, hundreds, tens, units}, registered.
- `done`  out  1  one-cycle pulse; `bcd_out`, `done_id` and `overflow` are valid this cycle and hold until the next `done`.
- `done_id`  out  1  port served by the current result.
- `overflow`  out  1  operand was greater than OVF_LIMIT.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE → LOAD → ADD ⇄ SHIFT → FINISH → IDLE.
- IDLE, when neither ack0 nor ack1 is high this cycle and any req is high:
  - Grant per the round-robin pointer `last`. Sole requester wins. If both request, the port ≠ `last` wins.
  - Latch the winner's operand into `binary_in`.
  - Latch `ovf_pend = (operand > OVF_LIMIT)`.
  - Set `last` = winner and go to LOAD.
- LOAD: `load_en=1`; go to ADD.
- ADD: `add_en=1`; go to SHIFT. If `bit_count==0` (guard), go to FINISH.
- SHIFT: `shift_en=1`. If `bit_count==1`, the last shift is happening this cycle; go to FINISH. Otherwise go to ADD.
- FINISH: no strobes. At the exit edge:
  - `bcd_out <= shift_reg[31:16]`, `done <= 1`.
  - `ack[grant] <= 1`, `done_id <= grant`.
  - `overflow <= ovf_pend`.
  - Go to IDLE.
- Requests are ignored in the IDLE cycle where the ack pulse is high. A req still high in the following cycle is a new request.
- Overflow operands are converted anyway: `bcd_out` = operand mod 10000, in BCD.
- The datapath is not reset by this block. LOAD fully reinitializes it.

## Timing
- Reset values:
  - All strobes, `done`, `ack0/1`, `busy`, `overflow`, `done_id` = 0.
  - `bcd_out` = 0, `binary_in` = 0, state = IDLE.
  - `last` = 1, so port 0 wins the first tie.
- Latency, with cycle 0 = first IDLE cycle with req high:
  - LOAD = cycle 1; ADD/SHIFT pairs = cycles 2–33.
  - FINISH = cycle 34; `done`/ack high in cycle 35.
- Strobe counts per conversion: `load_en` 1, `add_en` 16, `shift_en` 16.
- Throughput: a request held continuously (new operand) is re-granted in cycle 36 and produces its next done in cycle 71.
- Reset asserted mid-conversion:
  - Immediate return to IDLE with all outputs cleared.
  - No `done` or ack for the aborted request.
  - The requester must re-request.
- A req dropped before grant is never served. A req dropped after grant does not abort the conversion; its ack still pulses.

## Test plan
- Reset, then req0 with bin0=1234 → `done`/ack0 in cycle 35, `bcd_out`=16'h1234, `done_id`=0, `overflow`=0; exactly 16 add and 16 shift strobes.
- bin0=0, then bin0=9999 → `bcd_out`=16'h0000, then 16'h9999; `overflow`=0 both times.
- req0 and req1 rise together, with bin0=7 and bin1=42, held until ack → port 0 served first (16'h0007), then port 1 (16'h0042, `done_id`=1); tie alternation continues on the next simultaneous request.
- bin1=65535 → `overflow`=1, `bcd_out`=16'h5535; bin1=10000 → `overflow`=1, `bcd_out`=16'h0000.
- `reset` low in cycle 20 of a conversion → all outputs 0 immediately, no `done`; after release, a new req with 250 → 16'h0250 at cycle 35.
- Requester drops req the cycle after ack → exactly one conversion, `busy` returns to 0; req held through ack → second conversion starts in cycle 36.
